axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-requester AXI read-channel arbiter placed in front of the single AXI slave (axi_slave) read port.
- Arbitrates the AR channel round-robin and locks the grant for one complete burst.
- Routes the R beats of that burst back to the granted requester only.
- Checks burst length against RLAST and flags violations. The bench instantiates it so two read agents share one DUT.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- arst  in  1  reset, asynchronous, active-low (asserted when 0).
- s_arid  in  2*ID_W  requester AR ID; requester n occupies slice [n*ID_W +: ID_W] (same packing for all s_* vectors).
- s_araddr  in  2*ADDR_W  requester AR address.
- s_arlen  in  16  requester burst length-1, 8 bits each.
- s_arsize  in  6  3 bits each.
- s_arburst  in  4  2 bits each.
- s_arvalid  in  2  per-requester AR valid.
- s_arready  out  2  per-requester AR ready.
- s_rid  out  ID_W  R ID, broadcast to both requesters.
- s_rdata  out  DATA_W  R data, broadcast.
- s_rresp  out  2  R response, broadcast.
- s_rlast  out  1  R last, broadcast.
- s_rvalid  out  2  per-requester R valid; only the granted bit can be 1.
- s_rready  in  2  per-requester R ready.
- m_arid/m_araddr/m_arlen/m_arsize/m_arburst  out  ID_W/ADDR_W/8/3/2  AR to slave.
- m_arvalid  out  1
- m_arready  in  1
- m_rid/m_rdata/m_rresp/m_rlast  in  ID_W/DATA_W/2/1  R from slave.
- m_rvalid  in  1
- m_rready  out  1
- grant  out  1  index of current or last granted requester.
- busy  out  1  high in ADDR or DATA.
- proto_err  out  1  sticky burst-length error.

Behaviour:
- Reset (arst=0, asynchronous):
  - state=IDLE, grant=1 (so requester 0 wins first), beat_cnt=0, len_q=0, proto_err=0.
  - m_arvalid=0, m_rready=0, s_arready=0, s_rvalid=0.
  - Reset mid-burst abandons the burst; no completion is generated.
- IDLE:
  - All handshake outputs are 0; m_rready=0, so stray R beats stall.
  - If any s_arvalid is set: if exactly one is set, that requester wins; if both are set, the winner is ~grant.
  - Registers the winner into grant and moves to ADDR. Minimum latency from s_arvalid to m_arvalid is 1 cycle.
- ADDR:
  - m_arvalid=1; m_ar* are combinationally muxed from the granted slice.
  - s_arready[grant]=m_arready; the other bit is 0.
  - On m_arvalid&&m_arready: len_q=m_arlen, beat_cnt=0, go to DATA.
  - Requesters hold AR stable while valid (AXI rule); the arbiter does not re-arbitrate in ADDR.
- DATA:
  - s_rvalid[grant]=m_rvalid; m_rready=s_rready[grant]; s_r* mirror m_r*.
  - The non-granted requester sees s_rvalid=0 and its s_arready stays 0, so its pending request waits.
  - Each R handshake increments beat_cnt (8-bit).
  - If m_rlast=1 and beat_cnt!=len_q, set proto_err.
  - If m_rlast=0 and beat_cnt==len_q, set proto_err and keep routing until RLAST.
  - An R handshake with m_rlast=1 returns to IDLE (grant retained for round-robin), so at most one burst is outstanding.
- Back-to-back: with both requesters continuously valid, grants alternate 0,1,0,1. IDLE costs exactly 1 cycle between bursts.
- busy = (state!=IDLE).
- proto_err clears only on reset.

Test Plan:
- Reset then s_arvalid=2'b01, araddr0=0x100, arlen0=3 → m_arvalid one cycle later with m_araddr=0x100; 4 R beats reach s_rvalid[0] only; busy drops after the RLAST handshake.
- Both s_arvalid high after reset (addr0=0x000, addr1=0x200, arlen=0 each) → grant sequence 0 then 1; m_araddr 0x000 then 0x200; s_arready[1] stays 0 until the first RLAST handshake.
- Requester 1 raises arvalid during requester 0's DATA phase (arlen0=7) → m_arvalid stays 0 until 8 beats complete, then grant=1.
- m_arready held low for 5 cycles in ADDR → m_arvalid and m_ar* stay stable; s_arready[grant]=0; transfer to DATA occurs on the cycle m_arready=1.
- arlen=3 with the slave asserting RLAST on beat 2 → proto_err=1 and stays 1 after return to IDLE; arlen=1 with no RLAST on beat 2 → proto_err=1.
- Assert arst=0 mid-DATA (beat 2 of 4) → all outputs 0 asynchronously; after release the next request from requester 0 is granted first.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read-channel arbiter: round-robin AR arbitration, grant held
// for one whole burst, R beats steered to the granted requester only.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no burst outstanding; picks a winner from s_arvalid
// ST_ADDR | presenting the granted requester's AR to the slave
// ST_DATA | routing R beats of the accepted burst back to the granted requester
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [2*ID_W-1:0]   s_arid,
    input  logic [2*ADDR_W-1:0] s_araddr,
    input  logic [15:0]         s_arlen,
    input  logic [5:0]          s_arsize,
    input  logic [3:0]          s_arburst,
    input  logic [1:0]          s_arvalid,
    output logic [1:0]          s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic [1:0]          s_rvalid,
    input  logic [1:0]          s_rready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic                grant,
    output logic                busy,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        w_grant_nxt;
    logic [7:0]  r_beat_cnt;
    logic [7:0]  r_len_q;
    logic        r_proto_err;

    logic [ID_W-1:0]   w_sel_arid;
    logic [ADDR_W-1:0] w_sel_araddr;
    logic [7:0]        w_sel_arlen;
    logic [2:0]        w_sel_arsize;
    logic [1:0]        w_sel_arburst;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_last_beat;

    assign w_sel_arid    = r_grant ? s_arid[ID_W +: ID_W]     : s_arid[0 +: ID_W];
    assign w_sel_araddr  = r_grant ? s_araddr[ADDR_W +: ADDR_W] : s_araddr[0 +: ADDR_W];
    assign w_sel_arlen   = r_grant ? s_arlen[15:8]   : s_arlen[7:0];
    assign w_sel_arsize  = r_grant ? s_arsize[5:3]   : s_arsize[2:0];
    assign w_sel_arburst = r_grant ? s_arburst[3:2]  : s_arburst[1:0];

    assign w_ar_hs     = (r_state == ST_ADDR) && m_arready;
    assign w_r_hs      = (r_state == ST_DATA) && m_rvalid && s_rready[r_grant];
    assign w_last_beat = (r_beat_cnt == r_len_q);

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // On a tie the previous loser wins; r_grant resets to 1 so requester 0 goes first.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (|s_arvalid) begin
                    w_state_nxt = ST_ADDR;
                    w_grant_nxt = (&s_arvalid) ? ~r_grant : s_arvalid[1];
                end
            end
            ST_ADDR: begin
                if (m_arready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_r_hs && m_rlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_grant     <= 1'b1;
            r_beat_cnt  <= 8'd0;
            r_len_q     <= 8'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_grant <= w_grant_nxt;
            if (w_ar_hs) begin
                r_len_q    <= w_sel_arlen;
                r_beat_cnt <= 8'd0;
            end else if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (m_rlast != w_last_beat) r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        s_arready = 2'b00;
        s_rvalid  = 2'b00;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = 2'b00;
        s_rlast   = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = 8'd0;
        m_arsize  = 3'd0;
        m_arburst = 2'd0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (r_state)
            ST_ADDR: begin
                m_arvalid          = 1'b1;
                m_arid             = w_sel_arid;
                m_araddr           = w_sel_araddr;
                m_arlen            = w_sel_arlen;
                m_arsize           = w_sel_arsize;
                m_arburst          = w_sel_arburst;
                s_arready[r_grant] = m_arready;
            end
            ST_DATA: begin
                s_rvalid[r_grant] = m_rvalid;
                m_rready          = s_rready[r_grant];
                s_rid             = m_rid;
                s_rdata           = m_rdata;
                s_rresp           = m_rresp;
                s_rlast           = m_rlast;
            end
            default: ;
        endcase
    end

    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: two requesters and a scripted slave
// driven from tasks; AR and R expectations are queued and popped on DUT output.
module tb_axi_rd_arbiter;

    logic        aclk;
    logic        arst;
    logic [7:0]  s_arid;
    logic [63:0] s_araddr;
    logic [15:0] s_arlen;
    logic [5:0]  s_arsize;
    logic [3:0]  s_arburst;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        grant;
    logic        busy;
    logic        proto_err;

    axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .arst(arst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .grant(grant),
        .busy(busy), .proto_err(proto_err)
    );

    typedef struct packed {
        logic        g;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct packed {
        logic        tgt;
        logic [31:0] data;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      n_chk;
    int      n_fail;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        s_arid = 8'h00; s_araddr = 64'h0; s_arlen = 16'h0;
        s_arsize = 6'h0; s_arburst = 4'h0; s_arvalid = 2'b00;
        s_rready = 2'b11; m_arready = 1'b0; m_rid = 4'h0;
        m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic apply_reset();
        arst = 1'b0;
        clear_inputs();
        @(negedge aclk);
        arst = 1'b1;
        @(negedge aclk);
    endtask

    task automatic wait_ar(input int max_cyc, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge aclk);
            cyc++;
            if (m_arvalid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic accept_ar(output logic [1:0] sar);
        m_arready = 1'b1;
        #1 sar = s_arready;
        @(negedge aclk);
        m_arready = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit last,
                              output logic [1:0] rv, output logic [31:0] rd);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rlast  = last;
        m_rid    = 4'h5;
        #1 rv = s_rvalid;
        rd = s_rdata;
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge aclk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_chk++; if (grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant: got %0b expected 1", grant); end
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %0b expected 0", proto_err); end
        n_chk++; if ({m_arvalid, m_rready, s_arready, s_rvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_handshakes: got %b expected 000000", {m_arvalid, m_rready, s_arready, s_rvalid}); end
        arst = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single();
        bit ok; int cyc; ar_exp_t e; r_exp_t re;
        logic [1:0] sar, rv; logic [31:0] rd;
        s_arid[3:0] = 4'h5; s_araddr[31:0] = 32'h100; s_arlen[7:0] = 8'd3;
        s_arvalid = 2'b01;
        ar_q.push_back('{g: 1'b0, addr: 32'h100, len: 8'd3});
        wait_ar(20, ok, cyc);
        n_chk++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL single_ar_latency: got ok=%0b cycles=%0d expected ok=1 cycles=1", ok, cyc); end
        e = ar_q.pop_front();
        n_chk++; if (grant !== e.g) begin n_fail++; $display("FAIL single_grant: got %0b expected %0b", grant, e.g); end
        n_chk++; if (m_araddr !== e.addr || m_arlen !== e.len) begin n_fail++; $display("FAIL single_ar: got addr=%h len=%0d expected addr=%h len=%0d", m_araddr, m_arlen, e.addr, e.len); end
        n_chk++; if (m_arid !== 4'h5) begin n_fail++; $display("FAIL single_arid: got %h expected 5", m_arid); end
        accept_ar(sar);
        s_arvalid[0] = 1'b0;
        n_chk++; if (sar !== 2'b01) begin n_fail++; $display("FAIL single_arready: got %b expected 01", sar); end
        for (int i = 0; i < 4; i++) begin
            r_q.push_back('{tgt: 1'b0, data: 32'hA000 + i});
            drive_beat(32'hA000 + i, (i == 3), rv, rd);
            re = r_q.pop_front();
            n_chk++; if (rv !== (re.tgt ? 2'b10 : 2'b01) || rd !== re.data) begin n_fail++; $display("FAIL single_beat%0d: got rvalid=%b data=%h expected rvalid=%b data=%h", i, rv, rd, re.tgt ? 2'b10 : 2'b01, re.data); end
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
    endtask

    task automatic test_both();
        bit ok; int cyc; ar_exp_t e; r_exp_t re;
        logic [1:0] sar, rv; logic [31:0] rd;
        apply_reset();
        s_araddr = {32'h200, 32'h000}; s_arlen = 16'h0000;
        s_arvalid = 2'b11;
        ar_q.push_back('{g: 1'b0, addr: 32'h000, len: 8'd0});
        ar_q.push_back('{g: 1'b1, addr: 32'h200, len: 8'd0});
        for (int k = 0; k < 2; k++) begin
            wait_ar(20, ok, cyc);
            n_chk++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL both_ar_latency%0d: got ok=%0b cycles=%0d expected ok=1 cycles=1", k, ok, cyc); end
            e = ar_q.pop_front();
            n_chk++; if (grant !== e.g || m_araddr !== e.addr) begin n_fail++; $display("FAIL both_grant%0d: got grant=%0b addr=%h expected grant=%0b addr=%h", k, grant, m_araddr, e.g, e.addr); end
            accept_ar(sar);
            s_arvalid[e.g] = 1'b0;
            n_chk++; if (sar !== (e.g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL both_arready%0d: got %b expected %b", k, sar, e.g ? 2'b10 : 2'b01); end
            n_chk++; if (s_arready !== 2'b00) begin n_fail++; $display("FAIL both_arready_data%0d: got %b expected 00", k, s_arready); end
            r_q.push_back('{tgt: e.g, data: 32'hB000 + k});
            drive_beat(32'hB000 + k, 1'b1, rv, rd);
            re = r_q.pop_front();
            n_chk++; if (rv !== (re.tgt ? 2'b10 : 2'b01) || rd !== re.data) begin n_fail++; $display("FAIL both_beat%0d: got rvalid=%b data=%h expected rvalid=%b data=%h", k, rv, rd, re.tgt ? 2'b10 : 2'b01, re.data); end
        end
    endtask

    task automatic test_overlap();
        bit ok; int cyc; ar_exp_t e; r_exp_t re;
        logic [1:0] sar, rv; logic [31:0] rd;
        s_araddr[31:0] = 32'h400; s_arlen[7:0] = 8'd7; s_arvalid = 2'b01;
        ar_q.push_back('{g: 1'b0, addr: 32'h400, len: 8'd7});
        wait_ar(20, ok, cyc);
        e = ar_q.pop_front();
        n_chk++; if (!ok || grant !== e.g || m_arlen !== e.len) begin n_fail++; $display("FAIL overlap_ar0: got ok=%0b grant=%0b len=%0d expected ok=1 grant=%0b len=%0d", ok, grant, m_arlen, e.g, e.len); end
        accept_ar(sar);
        s_arvalid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                s_araddr[63:32] = 32'h500; s_arlen[15:8] = 8'd0; s_arvalid[1] = 1'b1;
                ar_q.push_back('{g: 1'b1, addr: 32'h500, len: 8'd0});
            end
            r_q.push_back('{tgt: 1'b0, data: 32'hC000 + i});
            drive_beat(32'hC000 + i, (i == 7), rv, rd);
            re = r_q.pop_front();
            n_chk++; if (rv !== (re.tgt ? 2'b10 : 2'b01) || rd !== re.data) begin n_fail++; $display("FAIL overlap_beat%0d: got rvalid=%b data=%h expected rvalid=%b data=%h", i, rv, rd, re.tgt ? 2'b10 : 2'b01, re.data); end
            n_chk++; if (m_arvalid !== 1'b0 || s_arready !== 2'b00) begin n_fail++; $display("FAIL overlap_hold%0d: got arvalid=%0b arready=%b expected arvalid=0 arready=00", i, m_arvalid, s_arready); end
        end
        wait_ar(20, ok, cyc);
        e = ar_q.pop_front();
        n_chk++; if (!ok || cyc != 1 || grant !== e.g || m_araddr !== e.addr) begin n_fail++; $display("FAIL overlap_ar1: got ok=%0b cycles=%0d grant=%0b addr=%h expected ok=1 cycles=1 grant=%0b addr=%h", ok, cyc, grant, m_araddr, e.g, e.addr); end
        accept_ar(sar);
        s_arvalid[1] = 1'b0;
        r_q.push_back('{tgt: 1'b1, data: 32'hC100});
        drive_beat(32'hC100, 1'b1, rv, rd);
        re = r_q.pop_front();
        n_chk++; if (rv !== (re.tgt ? 2'b10 : 2'b01) || rd !== re.data) begin n_fail++; $display("FAIL overlap_beat_r1: got rvalid=%b data=%h expected rvalid=%b data=%h", rv, rd, re.tgt ? 2'b10 : 2'b01, re.data); end
    endtask

    task automatic test_stall();
        bit ok; int cyc; ar_exp_t e;
        logic [1:0] sar, rv; logic [31:0] rd;
        s_arid[3:0] = 4'h3; s_araddr[31:0] = 32'h340; s_arlen[7:0] = 8'd0;
        s_arsize[2:0] = 3'd2; s_arburst[1:0] = 2'd1; s_arvalid = 2'b01;
        ar_q.push_back('{g: 1'b0, addr: 32'h340, len: 8'd0});
        wait_ar(20, ok, cyc);
        e = ar_q.pop_front();
        n_chk++; if (!ok || grant !== e.g) begin n_fail++; $display("FAIL stall_grant: got ok=%0b grant=%0b expected ok=1 grant=%0b", ok, grant, e.g); end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (m_arvalid !== 1'b1 || m_araddr !== e.addr || m_arid !== 4'h3 || m_arsize !== 3'd2 || m_arburst !== 2'd1) begin n_fail++; $display("FAIL stall_hold%0d: got arvalid=%0b addr=%h id=%h size=%0d burst=%0d expected arvalid=1 addr=%h id=3 size=2 burst=1", i, m_arvalid, m_araddr, m_arid, m_arsize, m_arburst, e.addr); end
            n_chk++; if (s_arready !== 2'b00 || m_rready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got arready=%b rready=%0b expected arready=00 rready=0", i, s_arready, m_rready); end
            @(negedge aclk);
        end
        accept_ar(sar);
        s_arvalid[0] = 1'b0;
        n_chk++; if (sar !== 2'b01 || m_arvalid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got arready=%b arvalid=%0b busy=%0b expected arready=01 arvalid=0 busy=1", sar, m_arvalid, busy); end
        drive_beat(32'hD000, 1'b1, rv, rd);
        n_chk++; if (rv !== 2'b01 || rd !== 32'hD000 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_beat: got rvalid=%b data=%h busy=%0b expected rvalid=01 data=d000 busy=0", rv, rd, busy); end
    endtask

    task automatic test_proto_err();
        bit ok; int cyc;
        logic [1:0] sar, rv; logic [31:0] rd;
        apply_reset();
        s_araddr[31:0] = 32'h600; s_arlen[7:0] = 8'd3; s_arvalid = 2'b01;
        wait_ar(20, ok, cyc);
        accept_ar(sar);
        s_arvalid = 2'b00;
        drive_beat(32'hE000, 1'b0, rv, rd);
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_early_clean: got %0b expected 0", proto_err); end
        drive_beat(32'hE001, 1'b1, rv, rd);
        n_chk++; if (proto_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL proto_early_last: got err=%0b busy=%0b expected err=1 busy=0", proto_err, busy); end
        repeat (3) @(negedge aclk);
        n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %0b expected 1", proto_err); end
        apply_reset();
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_reset_clear: got %0b expected 0", proto_err); end
        s_araddr[31:0] = 32'h680; s_arlen[7:0] = 8'd1; s_arvalid = 2'b01;
        wait_ar(20, ok, cyc);
        accept_ar(sar);
        s_arvalid = 2'b00;
        drive_beat(32'hE100, 1'b0, rv, rd);
        n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_late_beat0: got %0b expected 0", proto_err); end
        drive_beat(32'hE101, 1'b0, rv, rd);
        n_chk++; if (proto_err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL proto_missing_last: got err=%0b busy=%0b expected err=1 busy=1", proto_err, busy); end
        drive_beat(32'hE102, 1'b1, rv, rd);
        n_chk++; if (rv !== 2'b01 || proto_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL proto_late_last: got rvalid=%b err=%0b busy=%0b expected rvalid=01 err=1 busy=0", rv, proto_err, busy); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok; int cyc; ar_exp_t e; r_exp_t re;
        logic [1:0] sar, rv; logic [31:0] rd;
        s_araddr[31:0] = 32'h700; s_arlen[7:0] = 8'd3; s_arvalid = 2'b01;
        wait_ar(20, ok, cyc);
        accept_ar(sar);
        s_arvalid = 2'b00;
        drive_beat(32'hF000, 1'b0, rv, rd);
        drive_beat(32'hF001, 1'b0, rv, rd);
        m_rvalid = 1'b1; m_rdata = 32'hF002;
        #1;
        n_chk++; if (s_rvalid !== 2'b01) begin n_fail++; $display("FAIL midrst_pre: got rvalid=%b expected 01", s_rvalid); end
        arst = 1'b0;
        #1;
        n_chk++; if ({m_arvalid, m_rready, s_arready, s_rvalid, busy, proto_err} !== 8'b0) begin n_fail++; $display("FAIL midrst_outputs: got %b expected 00000000", {m_arvalid, m_rready, s_arready, s_rvalid, busy, proto_err}); end
        n_chk++; if (grant !== 1'b1) begin n_fail++; $display("FAIL midrst_grant: got %0b expected 1", grant); end
        m_rvalid = 1'b0;
        @(negedge aclk);
        arst = 1'b1;
        s_araddr = {32'h900, 32'h800}; s_arlen = 16'h0000; s_arvalid = 2'b11;
        ar_q.push_back('{g: 1'b0, addr: 32'h800, len: 8'd0});
        ar_q.push_back('{g: 1'b1, addr: 32'h900, len: 8'd0});
        for (int k = 0; k < 2; k++) begin
            wait_ar(20, ok, cyc);
            e = ar_q.pop_front();
            n_chk++; if (!ok || grant !== e.g || m_araddr !== e.addr) begin n_fail++; $display("FAIL midrst_regrant%0d: got ok=%0b grant=%0b addr=%h expected ok=1 grant=%0b addr=%h", k, ok, grant, m_araddr, e.g, e.addr); end
            accept_ar(sar);
            s_arvalid[e.g] = 1'b0;
            r_q.push_back('{tgt: e.g, data: 32'h1234_0000 + k});
            drive_beat(32'h1234_0000 + k, 1'b1, rv, rd);
            re = r_q.pop_front();
            n_chk++; if (rv !== (re.tgt ? 2'b10 : 2'b01) || rd !== re.data) begin n_fail++; $display("FAIL midrst_beat%0d: got rvalid=%b data=%h expected rvalid=%b data=%h", k, rv, rd, re.tgt ? 2'b10 : 2'b01, re.data); end
        end
        n_chk++; if (proto_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_end: got err=%0b busy=%0b expected err=0 busy=0", proto_err, busy); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_both();
        test_overlap();
        test_stall();
        test_proto_err();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
